// File: rtl/feature_frame_fifo.sv
// Store-and-forward AXI-Stream frame buffer: frames are released only once complete, oversize frames are dropped whole.
// Optional statistics outputs (frames_pending, drop_count, drop_pulse) are built when FRAME_FIFO_STATS_EN is defined.
module feature_frame_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     frames_pending,
    output logic [15:0]                drop_count,
    output logic                       drop_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    wr_state_t state, state_next;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] out_entry;

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] used, committed, cur_len;
    logic          s_fire, overflow;
    logic          wr_en, do_commit, do_rewind;
    logic          rd_avail, out_load;

    assign used      = wr_ptr - rd_ptr;
    assign committed = commit_ptr - rd_ptr;
    assign cur_len   = wr_ptr - commit_ptr;
    assign overflow  = (cur_len == FULL_LEVEL);

    // Only stall when committed frames occupy space that a drain will free;
    // a lone oversize frame must keep flowing so it can be discarded.
    assign s_axis_tready = !((used == FULL_LEVEL) && (committed != '0));
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s_fire && !s_axis_tlast) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (s_fire) begin
                    if (overflow) begin
                        state_next = s_axis_tlast ? IDLE : DROP;
                    end else if (s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_fire && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        do_commit = 1'b0;
        do_rewind = 1'b0;
        case (state)
            IDLE: begin
                wr_en     = s_fire;
                do_commit = s_fire && s_axis_tlast;
            end
            FILL: begin
                if (s_fire) begin
                    if (overflow) begin
                        do_rewind = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        do_commit = s_axis_tlast;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            if (do_rewind) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_commit) begin
                commit_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Output register refills on the handshake cycle itself, so no bubble between beats.
    assign rd_avail = (rd_ptr != commit_ptr);
    assign out_load = rd_avail && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            out_entry     <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (out_load) begin
            rd_ptr        <= rd_ptr + PTR_ONE;
            out_entry     <= mem[rd_ptr[AW-1:0]];
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign m_axis_tlast = out_entry[EW-1];
    assign m_axis_tkeep = out_entry[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tdata = out_entry[DATA_WIDTH-1:0];

`ifdef FRAME_FIFO_STATS_EN
    logic drop_evt, out_last_fire;

    assign drop_evt      = s_fire && s_axis_tlast &&
                           ((state == DROP) || ((state == FILL) && overflow));
    assign out_last_fire = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_pending <= '0;
            drop_count     <= '0;
            drop_pulse     <= 1'b0;
        end else begin
            if (do_commit && !out_last_fire) begin
                frames_pending <= frames_pending + PTR_ONE;
            end else if (!do_commit && out_last_fire) begin
                frames_pending <= frames_pending - PTR_ONE;
            end
            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
            drop_pulse <= drop_evt;
        end
    end
`else
    assign frames_pending = '0;
    assign drop_count     = '0;
    assign drop_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_feature_frame_fifo.sv
// Directed self-checking bench for feature_frame_fifo; expectations follow FRAME_FIFO_STATS_EN when it is defined.
module tb_feature_frame_fifo;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 64;
    localparam int PW    = 7;
`ifdef FRAME_FIFO_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [PW-1:0] frames_pending;
    logic [15:0]   drop_count;
    logic          drop_pulse;

    feature_frame_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_tdata),
        .s_axis_tkeep   (s_tkeep),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tvalid  (m_valid),
        .m_axis_tready  (m_ready),
        .m_axis_tlast   (m_last),
        .frames_pending (frames_pending),
        .drop_count     (drop_count),
        .drop_pulse     (drop_pulse)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ready_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: stalled, 1: always ready, 2: deterministic sparse pattern
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ((cyc % 5) == 0) || ((cyc % 7) == 0);
            endcase
        end
    end

    logic [DW-1:0] q_data[$];
    logic [KW-1:0] q_keep[$];
    logic          q_last[$];
    int            q_cyc[$];
    int            first_valid_cyc = -1;
    int            pend_max = 0;
    int            pulse_cnt = 0;
    int            stab_err = 0;
    bit            prev_stall = 0;
    logic [36:0]   prev_beat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!m_valid || ({m_last, m_tkeep, m_tdata} !== prev_beat)))
                stab_err++;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                q_data.push_back(m_tdata);
                q_keep.push_back(m_tkeep);
                q_last.push_back(m_last);
                q_cyc.push_back(cyc);
            end
            if (int'(frames_pending) > pend_max) pend_max = int'(frames_pending);
            if (drop_pulse) pulse_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_tkeep, m_tdata};
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_cyc.delete();
        first_valid_cyc = -1;
        pend_max  = 0;
        pulse_cnt = 0;
        stab_err  = 0;
    endtask

    // Returns aligned at #1 after the accepting edge; 'at' is that edge's cycle number.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             output bit ok, output int at);
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        ok = 0; at = -1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (s_tready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1;
                at = cyc;
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n, input int base, input int step, input logic [KW-1:0] lk,
                              output int acc, output int last_at);
        bit ok;
        int at;
        acc = 0; last_at = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            send_beat(DW'(base + i * step), (i == n - 1) ? lk : 4'hF, (i == n - 1), ok, at);
            if (!ok) break;
            acc++;
            last_at = at;
        end
    endtask

    task automatic wait_out(input int n, input int maxc, output bit ok);
        ok = 0;
        for (int c = 0; c < maxc; c++) begin
            if (q_data.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_tready: got %b want 1", s_tready); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", m_valid); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b want 0", m_last); end
        tests++; if (m_tdata !== '0 || m_tkeep !== '0) begin fails++; $display("FAIL reset_data: got %h/%h want 0/0", m_tdata, m_tkeep); end
        tests++; if (frames_pending !== '0 || drop_count !== '0 || drop_pulse !== 1'b0) begin
            fails++; $display("FAIL reset_stats: got %0d/%0d/%b want 0/0/0", frames_pending, drop_count, drop_pulse); end
    endtask

    task automatic test_single();
        int acc, at;
        bit ok;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        clear_mon();
        send_frame(4, 'h11, 'h11, 4'hF, acc, at);
        tests++; if (acc !== 4) begin fails++; $display("FAIL single_accept: got %0d want 4", acc); end
        @(negedge clk);
        tests++; if (frames_pending !== PW'(STATS)) begin fails++; $display("FAIL single_pend_commit: got %0d want %0d", frames_pending, STATS); end
        wait_out(4, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_timeout: got %0d beats want 4", q_data.size()); end
        tests++; if (first_valid_cyc !== at + 1) begin fails++; $display("FAIL single_latency: got cycle %0d want %0d", first_valid_cyc, at + 1); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== DW'('h11 * (i + 1)) || q_keep[i] !== 4'hF || q_last[i] !== (i == 3) || q_cyc[i] !== at + 1 + i) begin
                fails++;
                $display("FAIL single_beat%0d: got d=%h k=%h l=%b c=%0d want d=%h k=f l=%b c=%0d",
                         i, q_data[i], q_keep[i], q_last[i], q_cyc[i], DW'('h11 * (i + 1)), (i == 3), at + 1 + i);
            end
        end
        repeat (3) @(negedge clk);
        tests++; if (frames_pending !== '0) begin fails++; $display("FAIL single_pend_drain: got %0d want 0", frames_pending); end
    endtask

    task automatic test_backpressure();
        int acc, at;
        bit ok;
        ready_mode = 2;
        clear_mon();
        for (int f = 0; f < 3; f++) begin
            send_frame(8, 'h100 * (f + 1), 1, 4'h3, acc, at);
            tests++; if (acc !== 8) begin fails++; $display("FAIL bp_accept%0d: got %0d want 8", f, acc); end
        end
        wait_out(24, 2000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: got %0d beats want 24", q_data.size()); end
        for (int i = 0; i < 24 && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== DW'('h100 * (i / 8 + 1) + i % 8) || q_keep[i] !== ((i % 8 == 7) ? 4'h3 : 4'hF) || q_last[i] !== (i % 8 == 7)) begin
                fails++;
                $display("FAIL bp_beat%0d: got d=%h k=%h l=%b want d=%h l=%b",
                         i, q_data[i], q_keep[i], q_last[i], DW'('h100 * (i / 8 + 1) + i % 8), (i % 8 == 7));
            end
        end
        tests++; if (stab_err !== 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
        tests++; if (pend_max !== 3 * STATS) begin fails++; $display("FAIL bp_pend_peak: got %0d want %0d", pend_max, 3 * STATS); end
        repeat (12) @(negedge clk);
        tests++; if (frames_pending !== '0) begin fails++; $display("FAIL bp_pend_drain: got %0d want 0", frames_pending); end
    endtask

    task automatic test_exact_full();
        int acc, at;
        bit ok;
        ready_mode = 1;
        clear_mon();
        send_frame(DEPTH, 'h1000, 1, 4'hF, acc, at);
        tests++; if (acc !== DEPTH) begin fails++; $display("FAIL full_accept: got %0d want %0d", acc, DEPTH); end
        wait_out(DEPTH, 500, ok);
        repeat (4) @(negedge clk);
        tests++; if (q_data.size() !== DEPTH) begin fails++; $display("FAIL full_count: got %0d want %0d", q_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== DW'('h1000 + i) || q_last[i] !== (i == DEPTH - 1)) begin
                fails++; $display("FAIL full_beat%0d: got d=%h l=%b want d=%h l=%b", i, q_data[i], q_last[i], DW'('h1000 + i), (i == DEPTH - 1));
            end
        end
        tests++; if (drop_count !== '0) begin fails++; $display("FAIL full_drops: got %0d want 0", drop_count); end
    endtask

    task automatic test_oversize();
        int acc, at;
        bit ok;
        ready_mode = 1;
        clear_mon();
        send_frame(DEPTH + 1, 'h2000, 1, 4'hF, acc, at);
        tests++; if (acc !== DEPTH + 1) begin fails++; $display("FAIL over_accept: got %0d want %0d", acc, DEPTH + 1); end
        @(negedge clk);
        tests++; if (drop_pulse !== STATS[0]) begin fails++; $display("FAIL over_pulse_timing: got %b want %0d", drop_pulse, STATS); end
        repeat (4) @(negedge clk);
        tests++; if (q_data.size() !== 0) begin fails++; $display("FAIL over_leak: got %0d beats want 0", q_data.size()); end
        send_frame(2, 'h3000, 1, 4'h1, acc, at);
        wait_out(2, 200, ok);
        repeat (4) @(negedge clk);
        tests++; if (q_data.size() !== 2) begin fails++; $display("FAIL over_next_count: got %0d want 2", q_data.size()); end
        for (int i = 0; i < 2 && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== DW'('h3000 + i) || q_keep[i] !== ((i == 1) ? 4'h1 : 4'hF) || q_last[i] !== (i == 1)) begin
                fails++; $display("FAIL over_next_beat%0d: got d=%h k=%h l=%b want d=%h l=%b", i, q_data[i], q_keep[i], q_last[i], DW'('h3000 + i), (i == 1));
            end
        end
        tests++; if (pulse_cnt !== STATS) begin fails++; $display("FAIL over_pulse_count: got %0d want %0d", pulse_cnt, STATS); end
        tests++; if (drop_count !== 16'(STATS)) begin fails++; $display("FAIL over_drop_count: got %0d want %0d", drop_count, STATS); end
    endtask

    task automatic test_full_stall();
        int acc, at, acc2;
        bit ok;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        clear_mon();
        send_frame(60, 'h4000, 1, 4'hF, acc, at);
        tests++; if (acc !== 60) begin fails++; $display("FAIL stall_accept1: got %0d want 60", acc); end
        // The stalled output register already holds one beat of frame 1, freeing one entry: 5 beats fit.
        acc2 = 0;
        for (int i = 0; i < 5; i++) begin
            send_beat(DW'('h5000 + i), 4'hF, 1'b0, ok, at);
            if (ok) acc2++;
        end
        tests++; if (acc2 !== 5) begin fails++; $display("FAIL stall_accept2: got %0d want 5", acc2); end
        s_tdata = DW'('h5005); s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL stall_tready%0d: got %b want 0", i, s_tready); end
        end
        s_tvalid = 1'b0;
        ready_mode = 1;
        for (int i = 5; i < 10; i++) begin
            send_beat(DW'('h5000 + i), (i == 9) ? 4'h7 : 4'hF, (i == 9), ok, at);
            if (ok) acc2++;
        end
        tests++; if (acc2 !== 10) begin fails++; $display("FAIL stall_resume: got %0d want 10", acc2); end
        wait_out(70, 500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_timeout: got %0d beats want 70", q_data.size()); end
        for (int i = 0; i < 70 && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== ((i < 60) ? DW'('h4000 + i) : DW'('h5000 + i - 60)) || q_last[i] !== (i == 59 || i == 69) ||
                q_keep[i] !== ((i == 69) ? 4'h7 : 4'hF)) begin
                fails++; $display("FAIL stall_beat%0d: got d=%h k=%h l=%b", i, q_data[i], q_keep[i], q_last[i]);
            end
        end
        tests++; if (stab_err !== 0) begin fails++; $display("FAIL stall_stable: got %0d unstable stalls want 0", stab_err); end
    endtask

    task automatic test_reset_mid_frame();
        int acc, at;
        bit ok;
        ready_mode = 0;
        clear_mon();
        send_frame(2, 'h6000, 1, 4'hA, acc, at);
        repeat (2) @(negedge clk);
        tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b want 1", m_valid); end
        for (int i = 0; i < 3; i++) send_beat(DW'('h7000 + i), 4'hF, 1'b0, ok, at);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b/%b want 0/0", m_valid, m_last); end
        tests++; if (m_tdata !== '0 || m_tkeep !== '0) begin fails++; $display("FAIL rst_async_data: got %h/%h want 0/0", m_tdata, m_tkeep); end
        tests++; if (frames_pending !== '0 || drop_count !== '0 || drop_pulse !== 1'b0) begin
            fails++; $display("FAIL rst_async_stats: got %0d/%0d/%b want 0/0/0", frames_pending, drop_count, drop_pulse); end
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_async_tready: got %b want 1", s_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) @(negedge clk);
        clear_mon();
        send_frame(2, 'h8000, 1, 4'h5, acc, at);
        wait_out(2, 200, ok);
        repeat (4) @(negedge clk);
        tests++; if (q_data.size() !== 2) begin fails++; $display("FAIL rst_after_count: got %0d want 2", q_data.size()); end
        for (int i = 0; i < 2 && i < q_data.size(); i++) begin
            tests++;
            if (q_data[i] !== DW'('h8000 + i) || q_keep[i] !== ((i == 1) ? 4'h5 : 4'hF) || q_last[i] !== (i == 1)) begin
                fails++; $display("FAIL rst_after_beat%0d: got d=%h k=%h l=%b want d=%h l=%b", i, q_data[i], q_keep[i], q_last[i], DW'('h8000 + i), (i == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_exact_full();
        test_oversize();
        test_full_stall();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
